// File: rtl/selftrig_frame_builder.sv
// Self-trigger frame builder: records the filtered sample stream in a pretrigger ring buffer and
// emits one header/timestamp/sample frame per accepted trigger. Define SELFTRIG_TRAILER_EN to add
// a trailer word carrying the dropped-trigger count.
module selftrig_frame_builder #(
    parameter int unsigned PRE_SAMPLES  = 64,
    parameter int unsigned POST_SAMPLES = 192,
    parameter int unsigned ADDR_W       = 8,
    parameter logic [7:0]  CHANNEL_ID   = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] x,
    input  logic        trigger,
    input  logic [47:0] timestamp,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic [15:0] dropped
);

    localparam int unsigned FRAME_SAMPLES = PRE_SAMPLES + POST_SAMPLES;
    localparam int unsigned FW = $clog2(PRE_SAMPLES + 1);
    localparam int unsigned PW = $clog2(POST_SAMPLES + 1);
    localparam int unsigned DW = $clog2(FRAME_SAMPLES + 1);

    localparam logic [FW-1:0]     FILL_FULL    = FW'(PRE_SAMPLES);
    localparam logic [PW-1:0]     POST_LAST    = PW'(POST_SAMPLES - 1);
    localparam logic [DW-1:0]     DATA_N       = DW'(FRAME_SAMPLES);
    localparam logic [DW-1:0]     DATA_PENULT  = DW'(FRAME_SAMPLES - 1);
    localparam logic [ADDR_W-1:0] PRE_OFS      = ADDR_W'(PRE_SAMPLES);
    localparam logic [15:0]       HDR_WORD0    = {8'hDA, CHANNEL_ID};

`ifdef SELFTRIG_TRAILER_EN
    localparam bit TRAILER = 1'b1;
`else
    localparam bit TRAILER = 1'b0;
`endif

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StPost = 3'd1;
    localparam logic [2:0] StHdr  = 3'd2;
    localparam logic [2:0] StData = 3'd3;
`ifdef SELFTRIG_TRAILER_EN
    localparam logic [2:0] StTrl  = 3'd4;
`endif

    logic [2:0]        state_q;
    logic [ADDR_W-1:0] wp_q;
    logic [ADDR_W-1:0] raddr_q;
    logic [ADDR_W-1:0] raddr_d;
    logic [FW-1:0]     fill_q;
    logic [PW-1:0]     post_cnt_q;
    logic [DW-1:0]     data_cnt_q;
    logic [1:0]        hdr_idx_q;
    logic [47:0]       ts_q;
    logic [15:0]       rd_q;
    logic [15:0]       out_data_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic              busy_q;
    logic [15:0]       dropped_q;
    logic [15:0]       hdr_next;

    logic wr_en;
    logic accept;
    logic drop;
    logic xfer;

    logic [15:0] mem [0:(1 << ADDR_W) - 1];

    assign wr_en  = enable && (state_q == StIdle || state_q == StPost);
    assign accept = enable && trigger && (state_q == StIdle) && (fill_q == FILL_FULL);
    assign drop   = enable && trigger && !accept;
    assign xfer   = out_valid_q && out_ready;

    // Read address advances exactly when the output register takes rd_q, so rd_q always holds
    // mem[raddr_q] and the stream runs at one word per clock.
    always_comb begin
        raddr_d = raddr_q;
        if (accept) begin
            raddr_d = wp_q - PRE_OFS;
        end else if (xfer && ((state_q == StHdr && hdr_idx_q == 2'd3) ||
                              (state_q == StData && data_cnt_q != DATA_N))) begin
            raddr_d = raddr_q + 1'b1;
        end
    end

    always_comb begin
        hdr_next = ts_q[15:0];
        case (hdr_idx_q)
            2'd0:    hdr_next = ts_q[47:32];
            2'd1:    hdr_next = ts_q[31:16];
            default: hdr_next = ts_q[15:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wp_q] <= x;
        end
        rd_q <= mem[raddr_d];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            wp_q        <= '0;
            raddr_q     <= '0;
            fill_q      <= '0;
            post_cnt_q  <= '0;
            data_cnt_q  <= '0;
            hdr_idx_q   <= '0;
            ts_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            dropped_q   <= '0;
        end else begin
            raddr_q <= raddr_d;
            if (wr_en) begin
                wp_q <= wp_q + 1'b1;
            end
            if (drop && dropped_q != 16'hFFFF) begin
                dropped_q <= dropped_q + 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (enable && fill_q != FILL_FULL) begin
                        fill_q <= fill_q + 1'b1;
                    end
                    if (accept) begin
                        ts_q       <= timestamp;
                        busy_q     <= 1'b1;
                        post_cnt_q <= PW'(1);
                        if (POST_SAMPLES == 1) begin
                            state_q     <= StHdr;
                            hdr_idx_q   <= 2'd0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= HDR_WORD0;
                            out_last_q  <= 1'b0;
                        end else begin
                            state_q <= StPost;
                        end
                    end
                end

                StPost: begin
                    if (enable) begin
                        if (post_cnt_q == POST_LAST) begin
                            state_q     <= StHdr;
                            hdr_idx_q   <= 2'd0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= HDR_WORD0;
                            out_last_q  <= 1'b0;
                        end else begin
                            post_cnt_q <= post_cnt_q + 1'b1;
                        end
                    end
                end

                StHdr: begin
                    if (xfer) begin
                        if (hdr_idx_q == 2'd3) begin
                            state_q    <= StData;
                            out_data_q <= rd_q;
                            data_cnt_q <= DW'(1);
                            out_last_q <= 1'b0;
                        end else begin
                            out_data_q <= hdr_next;
                            hdr_idx_q  <= hdr_idx_q + 1'b1;
                        end
                    end
                end

                StData: begin
                    if (xfer) begin
                        if (data_cnt_q != DATA_N) begin
                            out_data_q <= rd_q;
                            data_cnt_q <= data_cnt_q + 1'b1;
                            out_last_q <= !TRAILER && (data_cnt_q == DATA_PENULT);
                        end else begin
`ifdef SELFTRIG_TRAILER_EN
                            state_q    <= StTrl;
                            out_data_q <= dropped_q;
                            out_last_q <= 1'b1;
`else
                            state_q     <= StIdle;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            fill_q      <= '0;
`endif
                        end
                    end
                end

`ifdef SELFTRIG_TRAILER_EN
                StTrl: begin
                    if (xfer) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        busy_q      <= 1'b0;
                        fill_q      <= '0;
                    end
                end
`endif

                default: state_q <= StIdle;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign dropped   = dropped_q;

endmodule

// File: tb/tb_selftrig_frame_builder.sv
// Scoreboard bench for selftrig_frame_builder: expected frames are queued when a trigger is
// driven and compared word by word as the DUT transfers them.
module tb_selftrig_frame_builder;

`ifdef SELFTRIG_TRAILER_EN
    localparam bit TRL = 1'b1;
`else
    localparam bit TRL = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] x;
    logic        trigger;
    logic [47:0] timestamp;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic [15:0] dropped;

    selftrig_frame_builder dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .x         (x),
        .trigger   (trigger),
        .timestamp (timestamp),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .dropped   (dropped)
    );

    int          checks = 0;
    int          errors = 0;
    logic [16:0] exp_q[$];
    int unsigned smp = 0;
    logic [47:0] ts = '0;
    bit          bp = 1'b0;
    int          mode = 0;
    logic        prev_hold = 1'b0;
    logic [16:0] prev_word = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] f(input int unsigned n);
        if (mode == 1) return 16'(n * 37) ^ 16'h8000;
        return n[15:0];
    endfunction

    task automatic push_frame(input int unsigned t, input logic [47:0] tv,
                              input logic [15:0] trl);
        exp_q.push_back({1'b0, 16'hDA00});
        exp_q.push_back({1'b0, tv[47:32]});
        exp_q.push_back({1'b0, tv[31:16]});
        exp_q.push_back({1'b0, tv[15:0]});
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back({(i == 255) && !TRL, f(t - 64 + i)});
        end
        if (TRL) exp_q.push_back({1'b1, trl});
    endtask

    task automatic tick(input bit trig);
        enable    = 1'b1;
        x         = f(smp);
        trigger   = trig;
        timestamp = ts;
        out_ready = bp ? ($urandom_range(9, 0) < 3) : 1'b1;
        @(posedge clk);
        #1;
        smp++;
        ts++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic wait_frame(input int bound, output int n);
        n = 0;
        while (n < bound && !(exp_q.size() == 0 && !busy)) begin
            tick(1'b0);
            n++;
        end
        check("frame_done", (exp_q.size() == 0) && !busy, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Monitor: scoreboard pop on each transfer, plus hold-stability under backpressure.
    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) check("hold", {out_valid, out_last, out_data}, {1'b1, prev_word});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", exp_q.size(), 1);
                end else begin
                    check("word", {out_last, out_data}, exp_q.pop_front());
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_word = {out_last, out_data};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int unsigned t;
        reset = 1'b1; enable = 1'b0; x = '0; trigger = 1'b0; timestamp = '0; out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_dropped", dropped, 0);
        reset = 1'b0;

        // Basic frame with header timing and throughput.
        ticks(100);
        ts = 48'h123456789ABC;
        push_frame(100, ts, 16'h0000);
        tick(1'b1);
        check("busy_rise", busy, 1);
        ticks(190);
        check("hdr_early", out_valid, 0);
        tick(1'b0);
        check("hdr_on_time", out_valid, 1);
        wait_frame(600, n);
        check("throughput", n <= 262, 1);
        check("s1_dropped", dropped, 0);
        check("s1_valid_low", out_valid, 0);

        // Insufficient pretrigger fill.
        do_reset();
        ticks(10);
        tick(1'b1);
        check("s2_dropped", dropped, 1);
        check("s2_busy", busy, 0);
        ticks(5);
        check("s2_busy_late", busy, 0);
        check("s2_valid", out_valid, 0);

        // Triggers during busy; non-ramp signed pattern.
        do_reset();
        mode = 1;
        ticks(100);
        ts = 48'hFEDCBA987654;
        push_frame(smp, ts, 16'h0003);
        tick(1'b1);
        for (int k = 1; k <= 300; k++) tick(k == 50 || k == 200 || k == 300);
        wait_frame(600, n);
        check("s3_dropped", dropped, 3);
        mode = 0;

        // Backpressure: same content as the basic frame.
        do_reset();
        smp = 0;
        bp = 1'b1;
        ticks(100);
        ts = 48'h123456789ABC;
        push_frame(100, ts, 16'h0000);
        tick(1'b1);
        wait_frame(4000, n);
        bp = 1'b0;
        check("s4_dropped", dropped, 0);

        // Wrap-around: wp sits at 36 here, so 278 more writes put the start address at 250.
        ticks(278);
        ts = 48'h00000000FFFF;
        push_frame(smp, ts, 16'h0000);
        tick(1'b1);
        wait_frame(600, n);

        // Abort mid-DATA, then refill boundary.
        ticks(70);
        push_frame(smp, ts, 16'h0000);
        tick(1'b1);
        ticks(235);
        check("s6_mid_valid", out_valid, 1);
        reset = 1'b1;
        #2;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_dropped", dropped, 0);
        ticks(63);
        tick(1'b1);
        check("refill_reject", dropped, 1);
        check("refill_busy", busy, 0);
        t = smp;
        push_frame(t, ts, 16'h0001);
        tick(1'b1);
        check("refill_accept", busy, 1);
        wait_frame(600, n);
        check("s6_dropped", dropped, 1);
        check("s6_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
